// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_ctrl
//  Purpose  : Run-time baud-rate change controller. Quiesces the UART,
//             drives a new rate code into baud_generator, restarts its
//             dividers, waits a settle window of oversample ticks and then
//             re-enables transmit and receive.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_ctrl #(
  parameter logic [1:0] DEFAULT_SEL  = 2'b00,
  parameter int         SETTLE_TICKS = 16,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter int         TO_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       inrx,
  output logic [1:0] baud_sel,
  output logic       gen_reset,
  output logic       tx_en,
  output logic       rx_en,
  output logic       done,
  output logic       err
);

  // Settle counter only needs to reach SETTLE_TICKS; keep at least one bit.
  localparam int              ST_W    = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_TICKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      pend_sel;
  logic [TO_W-1:0] to_cnt;
  logic [ST_W-1:0] st_cnt;
  logic [ST_W-1:0] st_cnt_inc;

  logic            accept;
  logic            quiet;
  logic            to_hit;
  logic            settled;

  logic            req_ready_nxt;
  logic [1:0]      baud_sel_nxt;
  logic            gen_reset_nxt;
  logic            tx_en_nxt;
  logic            rx_en_nxt;
  logic            done_nxt;
  logic            err_nxt;

  assign accept     = req_valid && req_ready;
  assign quiet      = !tx_busy && !rx_busy;
  assign to_hit     = (to_cnt == TO_LAST);
  // A tick arriving in the cycle that completes the window is counted.
  assign st_cnt_inc = st_cnt + ST_W'(inrx);
  assign settled    = (st_cnt_inc == ST_LAST);

  // Next-state selection and next values of every registered output.
  always_comb begin
    state_nxt     = state;
    req_ready_nxt = 1'b0;
    baud_sel_nxt  = baud_sel;
    gen_reset_nxt = 1'b0;
    tx_en_nxt     = tx_en;
    rx_en_nxt     = rx_en;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          // Same rate: nothing to reprogram, report completion directly.
          state_nxt = (req_sel == baud_sel) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Quiet UART wins over an expiring timeout in the same cycle.
        if (quiet) begin
          state_nxt = S_APPLY;
        end else if (to_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_APPLY: begin
        state_nxt = (SETTLE_TICKS == 0) ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settled) begin
          state_nxt = S_DONE;
        end else if (to_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Outputs follow the state being entered so they are valid with it.
    case (state_nxt)
      S_IDLE: begin
        req_ready_nxt = 1'b1;
        tx_en_nxt     = 1'b1;
        rx_en_nxt     = 1'b1;
      end
      S_DRAIN: begin
        tx_en_nxt = 1'b0;
        rx_en_nxt = 1'b1;
      end
      S_APPLY: begin
        baud_sel_nxt  = pend_sel;
        gen_reset_nxt = 1'b1;
        tx_en_nxt     = 1'b0;
        rx_en_nxt     = 1'b0;
      end
      S_SETTLE: begin
        tx_en_nxt = 1'b0;
        rx_en_nxt = 1'b0;
      end
      // Enables keep their prior level for the pulse cycle, then reopen in IDLE.
      S_DONE:  done_nxt = 1'b1;
      S_ABORT: err_nxt  = 1'b1;
      default: begin
        req_ready_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pend_sel  <= DEFAULT_SEL;
      to_cnt    <= '0;
      st_cnt    <= '0;
      req_ready <= 1'b1;
      baud_sel  <= DEFAULT_SEL;
      gen_reset <= 1'b0;
      tx_en     <= 1'b1;
      rx_en     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (accept) begin
        pend_sel <= req_sel;
      end
      // Timeout runs only while waiting on the UART or on the settle window.
      if ((state == S_DRAIN) || (state == S_SETTLE)) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      if (state == S_SETTLE) begin
        st_cnt <= st_cnt_inc;
      end else begin
        st_cnt <= '0;
      end
      req_ready <= req_ready_nxt;
      baud_sel  <= baud_sel_nxt;
      gen_reset <= gen_reset_nxt;
      tx_en     <= tx_en_nxt;
      rx_en     <= rx_en_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_baud_ctrl
//  Purpose  : Self-checking bench for uart_baud_ctrl. Stimulus windows are
//             built as input traces; a timeline model predicts every output
//             per cycle from the rate-change rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baud_ctrl;

  localparam int ST   = 4;
  localparam int TO   = 100;
  localparam int L    = 400;
  localparam int TAIL = 250;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       tx_busy;
  logic       rx_busy;
  logic       inrx;
  logic [1:0] baud_sel;
  logic       gen_reset;
  logic       tx_en;
  logic       rx_en;
  logic       done;
  logic       err;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  bit       rv  [L];
  bit [1:0] rs  [L];
  bit       txb [L];
  bit       rxb [L];
  bit       ixr [L];
  logic [7:0] exp_v [L];
  logic [1:0] cur_sel;

  uart_baud_ctrl #(
    .DEFAULT_SEL (2'b00),
    .SETTLE_TICKS(ST),
    .TIMEOUT_CYC (TO),
    .TO_W        (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .tx_busy  (tx_busy),
    .rx_busy  (rx_busy),
    .inrx     (inrx),
    .baud_sel (baud_sel),
    .gen_reset(gen_reset),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  assign outs = {req_ready, baud_sel, gen_reset, tx_en, rx_en, done, err};

  function automatic logic [7:0] pack(logic rdy, logic [1:0] sel, logic gen,
                                      logic tx, logic rx, logic dn, logic er);
    return {rdy, sel, gen, tx, rx, dn, er};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {rdy,sel,gen,tx,rx,done,err}=%b expected %b", tag, got, exp);
    end
  endtask

  // Timeline model: walks the window, and at each accepted request searches
  // the input traces for the quiet cycle, the settle completion or a timeout.
  task automatic build_expect();
    int c, d, s, cnt, last;
    logic [1:0] nsel;
    c = 0;
    while (c < L) begin
      exp_v[c] = pack(1'b1, cur_sel, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (rv[c]) begin
        if (rs[c] == cur_sel) begin
          exp_v[c+1] = pack(1'b0, cur_sel, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
          c = c + 2;
        end else begin
          nsel = rs[c];
          d = -1;
          for (int i = c + 1; i <= c + TO; i++)
            if (d < 0 && !txb[i] && !rxb[i]) d = i;
          last = (d < 0) ? c + TO : d;
          for (int i = c + 1; i <= last; i++)
            exp_v[i] = pack(1'b0, cur_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          if (d < 0) begin
            exp_v[last+1] = pack(1'b0, cur_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            c = last + 2;
          end else begin
            cur_sel = nsel;
            exp_v[d+1] = pack(1'b0, cur_sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            s = -1;
            cnt = 0;
            for (int i = d + 2; i <= d + 1 + TO; i++) begin
              if (s < 0) begin
                cnt += int'(ixr[i]);
                if (cnt == ST) s = i;
              end
            end
            last = (s < 0) ? d + 1 + TO : s;
            for (int i = d + 2; i <= last; i++)
              exp_v[i] = pack(1'b0, cur_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_v[last+1] = pack(1'b0, cur_sel, 1'b0, 1'b0, 1'b0, s >= 0, s < 0);
            c = last + 2;
          end
        end
      end else begin
        c++;
      end
    end
  endtask

  task automatic clear_traces();
    for (int c = 0; c < L; c++) begin
      rv[c] = 1'b0; rs[c] = 2'b00; txb[c] = 1'b0; rxb[c] = 1'b0;
      ixr[c] = (c % 10 == 0);
    end
  endtask

  task automatic gen_random(input int mode);
    int pb, pi;
    pb = (mode == 0) ? 10 : (mode == 2) ? 70 : 30;
    pi = (mode == 3) ? 40 : 5;
    for (int c = 0; c < L; c++) begin
      rv[c]  = (c < L - TAIL) && ($urandom_range(0, 7) == 0);
      rs[c]  = 2'($urandom_range(0, 3));
      txb[c] = (mode == 1) ? 1'b1 : ($urandom_range(0, 99) < pb);
      rxb[c] = ($urandom_range(0, 99) < pb / 2);
      ixr[c] = ($urandom_range(1, pi) == 1);
    end
  endtask

  task automatic run_scenario(input int id);
    build_expect();
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      check_eq($sformatf("s%0d_c%0d", id, c), outs, exp_v[c]);
      req_valid = rv[c];
      req_sel   = rs[c];
      tx_busy   = txb[c];
      rx_busy   = rxb[c];
      inrx      = ixr[c];
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_sel = 2'b11;
    tx_busy = 1'b0; rx_busy = 1'b0; inrx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_in_reset"}, outs, pack(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    reset = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_post%0d", tag, i), outs,
               pack(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    cur_sel = 2'b00;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_sel = 2'b00;
    tx_busy = 1'b0; rx_busy = 1'b0; inrx = 1'b0;
    apply_reset("rst");

    // 00 -> 01 with the transmitter busy for 50 cycles after accept
    clear_traces();
    rv[2] = 1'b1; rs[2] = 2'b01;
    for (int i = 3; i <= 52; i++) txb[i] = 1'b1;
    run_scenario(0);

    // idle UART, change to 11, oversample tick every 10 cycles
    clear_traces();
    rv[2] = 1'b1; rs[2] = 2'b11;
    run_scenario(1);

    // transmitter stuck busy: drain must time out, rate unchanged
    clear_traces();
    rv[2] = 1'b1; rs[2] = 2'b10;
    for (int i = 0; i < L; i++) txb[i] = 1'b1;
    run_scenario(2);

    // request for the rate already in use
    clear_traces();
    rv[2] = 1'b1; rs[2] = cur_sel;
    run_scenario(3);

    for (int k = 0; k < 12; k++) begin
      gen_random(k % 4);
      run_scenario(10 + k);
    end

    // reset in the middle of a change to 10
    apply_reset("rst2");
    req_valid = 1'b1; req_sel = 2'b10;
    @(negedge clk);
    check_eq("mid_drain", outs, pack(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_apply", outs, pack(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("mid_settle", outs, pack(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1; inrx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("after_abort_rst%0d", i), outs,
               pack(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
